// File: rtl/spi_frame_slave.sv
// Purpose: SPI slave receiver that assembles 8*WORD_BYTES-bit words and emits them with a 1-cycle strobe.
// Latency: o_valid/o_data update SYNC_STAGES clk edges after the edge that first captures the final sample SCLK edge.
// Backpressure: none; the word is presented for one cycle and o_data holds it until the next word or i_clear.
//
// Ports:
//   clk, reset            system clock (>= 4x SCLK), asynchronous active-low reset
//   i_sclk/i_mosi/i_ss_n  SPI pins from the master, asynchronous to clk
//   i_clear               synchronous clear of o_data and o_word_cnt
//   o_data, o_valid       last complete word and its 1-cycle update strobe
//   o_frame_err           1-cycle pulse when SS deasserts mid-word
//   o_busy                high while a frame is being shifted in
//   o_word_cnt            words received since reset/clear, wraps at 16 bits
module spi_frame_slave #(
    parameter int WORD_BYTES  = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_sclk,
    input  logic                    i_mosi,
    input  logic                    i_ss_n,
    input  logic                    i_clear,
    output logic [8*WORD_BYTES-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_frame_err,
    output logic                    o_busy,
    output logic [15:0]             o_word_cnt
);

    localparam int             BITS        = 8 * WORD_BYTES;
    localparam int             CW          = $clog2(BITS);
    localparam logic           SCLK_IDLE   = (CPOL != 0);
    localparam logic           SAMPLE_RISE = (CPOL == CPHA);
    localparam logic [CW-1:0]  LAST_BIT    = CW'(BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_prev;
    logic                   ss_prev;

    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ss_s;
    logic                   sample_edge;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   last_bit;
    logic [BITS-1:0]        next_word;

    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [BITS-1:0]        shreg;

    // SS chain resets to "asserted" so a frame already running at reset
    // release never produces a falling edge and is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
            mosi_sync <= '0;
            ss_sync   <= '0;
            sclk_prev <= SCLK_IDLE;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_ss_n};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    always_comb begin
        sclk_s      = sclk_sync[SYNC_STAGES-1];
        mosi_s      = mosi_sync[SYNC_STAGES-1];
        ss_s        = ss_sync[SYNC_STAGES-1];
        sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev);
        ss_fall     = ss_prev & ~ss_s;
        ss_rise     = ~ss_prev & ss_s;
        last_bit    = sample_edge && (bit_cnt == LAST_BIT);
        next_word   = (MSB_FIRST != 0) ? {shreg[BITS-2:0], mosi_s}
                                       : {mosi_s, shreg[BITS-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
            o_word_cnt  <= '0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= SHIFT;
                        o_busy  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    // A non-final bit arriving with SS release is dropped.
                    if (sample_edge && !(ss_rise && !last_bit)) begin
                        shreg   <= next_word;
                        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    end
                    if (last_bit && !i_clear) begin
                        o_data     <= next_word;
                        o_valid    <= 1'b1;
                        o_word_cnt <= o_word_cnt + 16'd1;
                    end
                    if (ss_rise) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        // A completing word wins over the framing error.
                        if (!last_bit && (bit_cnt != '0 || sample_edge))
                            o_frame_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
            // Clear takes priority over a word completing in the same cycle.
            if (i_clear) begin
                o_data     <= '0;
                o_word_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Purpose: directed + randomized bench for spi_frame_slave, mode-0 MSB-first and mode-3 LSB-first instances.
// Latency: checks o_valid lands SYNC_STAGES cycles after the capturing edge of the final sample edge.
// Backpressure: none; outputs sampled on the falling clk edge, inputs driven on the falling edge.
module tb_spi_frame_slave;

    localparam int H = 4;   // SCLK half period in clk cycles
    localparam int S = 2;   // synchroniser depth of both instances

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mosi;
    logic        sclk0, ss0, clr0;
    logic        sclk3, ss3, clr3;
    logic [15:0] data0, data3;
    logic        valid0, err0, busy0, valid3, err3, busy3;
    logic [15:0] cnt0, cnt3;

    spi_frame_slave #(.WORD_BYTES(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(S)) u_mode0 (
        .clk(clk), .reset(reset), .i_sclk(sclk0), .i_mosi(mosi), .i_ss_n(ss0), .i_clear(clr0),
        .o_data(data0), .o_valid(valid0), .o_frame_err(err0), .o_busy(busy0), .o_word_cnt(cnt0)
    );

    spi_frame_slave #(.WORD_BYTES(2), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(S)) u_mode3 (
        .clk(clk), .reset(reset), .i_sclk(sclk3), .i_mosi(mosi), .i_ss_n(ss3), .i_clear(clr3),
        .o_data(data3), .o_valid(valid3), .o_frame_err(err3), .o_busy(busy3), .o_word_cnt(cnt3)
    );

    int errors = 0;
    int checks = 0;
    int vcnt0 = 0, ecnt0 = 0, vcnt3 = 0, ecnt3 = 0, both = 0;
    logic [15:0] q0[$];
    logic [15:0] q3[$];

    // Event monitor: every valid strobe is logged with its word.
    always @(negedge clk) begin
        if (valid0) begin vcnt0++; q0.push_back(data0); end
        if (err0) ecnt0++;
        if (valid0 && err0) both++;
        if (valid3) begin vcnt3++; q3.push_back(data3); end
        if (err3) ecnt3++;
        if (valid3 && err3) both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // d=0 selects the mode-0 instance, d=1 the mode-3 instance
    task automatic set_ss(input int d, input logic v);
        if (d == 0) ss0 = v; else ss3 = v;
        wcyc(H);
    endtask

    task automatic send_bit(input int d, input logic b);
        if (d == 0) begin
            mosi = b; wcyc(H); sclk0 = 1'b1; wcyc(H); sclk0 = 1'b0;
        end else begin
            sclk3 = 1'b0; mosi = b; wcyc(H); sclk3 = 1'b1; wcyc(H);
        end
    endtask

    // Sends the first nbits of w in the wire order of the selected instance.
    task automatic send_word(input int d, input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++)
            send_bit(d, (d == 0) ? w[15-i] : w[i]);
    endtask

    task automatic frame(input int d, input logic [15:0] w);
        set_ss(d, 1'b0);
        send_word(d, w, 16);
        set_ss(d, 1'b1);
        wcyc(2);
    endtask

    initial begin
        int v, e, n, exp_cnt;
        logic [15:0] w;
        logic [15:0] expq[$];

        reset = 1'b0; mosi = 1'b0;
        sclk0 = 1'b0; ss0 = 1'b1; clr0 = 1'b0;
        sclk3 = 1'b1; ss3 = 1'b1; clr3 = 1'b0;
        wcyc(3);
        check("rst_data0", 32'(data0), 32'h0);
        check("rst_valid0", 32'(valid0), 32'h0);
        check("rst_err0", 32'(err0), 32'h0);
        check("rst_busy0", 32'(busy0), 32'h0);
        check("rst_cnt0", 32'(cnt0), 32'h0);
        check("rst_data3", 32'(data3), 32'h0);
        check("rst_cnt3", 32'(cnt3), 32'h0);
        reset = 1'b1;
        wcyc(4);
        check("idle_busy0", 32'(busy0), 32'h0);

        // single frame
        v = vcnt0; e = ecnt0;
        frame(0, 16'h1234);
        check("t1_data", 32'(data0), 32'h1234);
        check("t1_valids", 32'(vcnt0 - v), 32'd1);
        check("t1_cnt", 32'(cnt0), 32'd1);
        check("t1_err", 32'(ecnt0 - e), 32'd0);

        clr0 = 1'b1; wcyc(1); clr0 = 1'b0; wcyc(1);
        check("clr_data", 32'(data0), 32'h0);
        check("clr_cnt", 32'(cnt0), 32'h0);

        // two words under one SS
        q0.delete();
        set_ss(0, 1'b0);
        send_word(0, 16'h0005, 16);
        check("t2_busy_mid", 32'(busy0), 32'd1);
        send_word(0, 16'h0006, 16);
        set_ss(0, 1'b1);
        wcyc(2);
        check("t2_nwords", 32'(q0.size()), 32'd2);
        if (q0.size() == 2) begin
            check("t2_word0", 32'(q0[0]), 32'h0005);
            check("t2_word1", 32'(q0[1]), 32'h0006);
        end
        check("t2_cnt", 32'(cnt0), 32'd2);
        check("t2_busy_end", 32'(busy0), 32'd0);

        // framing error after 11 bits
        v = vcnt0; e = ecnt0;
        set_ss(0, 1'b0);
        send_word(0, 16'hFFFF, 11);
        set_ss(0, 1'b1);
        wcyc(2);
        check("t3_err", 32'(ecnt0 - e), 32'd1);
        check("t3_valids", 32'(vcnt0 - v), 32'd0);
        check("t3_data", 32'(data0), 32'h0006);
        check("t3_cnt", 32'(cnt0), 32'd2);
        check("t3_busy", 32'(busy0), 32'd0);

        w = 16'($urandom);
        frame(0, w);
        check("pre6_data", 32'(data0), 32'(w));
        check("pre6_cnt", 32'(cnt0), 32'd3);

        // clear in the completion cycle of 0x0007
        v = vcnt0; e = ecnt0;
        set_ss(0, 1'b0);
        send_word(0, 16'h0007, 15);
        mosi = 1'b1; wcyc(H);
        sclk0 = 1'b1;
        wcyc(S);
        clr0 = 1'b1; wcyc(1); clr0 = 1'b0;
        wcyc(1); sclk0 = 1'b0;
        set_ss(0, 1'b1);
        wcyc(2);
        check("t6_data", 32'(data0), 32'h0);
        check("t6_cnt", 32'(cnt0), 32'h0);
        check("t6_valids", 32'(vcnt0 - v), 32'd0);
        check("t6_err", 32'(ecnt0 - e), 32'd0);

        // randomized bursts against the queue model
        exp_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 3));
            q0.delete(); expq.delete();
            set_ss(0, 1'b0);
            for (int k = 0; k < n; k++) begin
                w = 16'($urandom);
                expq.push_back(w);
                send_word(0, w, 16);
            end
            set_ss(0, 1'b1);
            wcyc(2);
            exp_cnt += n;
            check("rnd0_nwords", 32'(q0.size()), 32'(n));
            for (int k = 0; k < n && k < q0.size(); k++)
                check("rnd0_word", 32'(q0[k]), 32'(expq[k]));
            check("rnd0_cnt", 32'(cnt0), 32'(exp_cnt & 16'hFFFF));
            check("rnd0_data", 32'(data0), 32'(expq[n-1]));
        end

        // reset in the middle of a frame, released with SS still low
        v = vcnt0; e = ecnt0;
        set_ss(0, 1'b0);
        send_word(0, 16'hABCD, 6);
        reset = 1'b0; wcyc(3); reset = 1'b1;
        v = vcnt0; e = ecnt0;
        send_word(0, 16'h5A5A, 10);
        set_ss(0, 1'b1);
        wcyc(2);
        check("t5_valids", 32'(vcnt0 - v), 32'd0);
        check("t5_err", 32'(ecnt0 - e), 32'd0);
        check("t5_cnt_hold", 32'(cnt0), 32'd0);
        frame(0, 16'h00FF);
        check("t5_data", 32'(data0), 32'h00FF);
        check("t5_cnt", 32'(cnt0), 32'd1);

        // mode 3, LSB first, with latency measurement on the final bit
        v = vcnt3; e = ecnt3;
        w = 16'hA5C3;
        set_ss(1, 1'b0);
        for (int i = 0; i < 15; i++) send_bit(1, w[i]);
        sclk3 = 1'b0; mosi = w[15]; wcyc(H);
        sclk3 = 1'b1;
        for (int k = 1; k <= S + 2; k++) begin
            wcyc(1);
            check("t4_valid_lat", 32'(valid3), 32'(k == S + 1));
            if (k == S + 1) check("t4_data", 32'(data3), 32'hA5C3);
        end
        set_ss(1, 1'b1);
        wcyc(2);
        check("t4_cnt", 32'(cnt3), 32'd1);
        check("t4_valids", 32'(vcnt3 - v), 32'd1);
        check("t4_err", 32'(ecnt3 - e), 32'd0);
        check("t4_busy", 32'(busy3), 32'd0);

        exp_cnt = 1;
        for (int r = 0; r < 3; r++) begin
            w = 16'($urandom);
            frame(1, w);
            exp_cnt++;
            check("rnd3_data", 32'(data3), 32'(w));
            check("rnd3_cnt", 32'(cnt3), 32'(exp_cnt));
        end

        // random partial frame on mode 3 -> one framing error, nothing else moves
        v = vcnt3; e = ecnt3;
        n = int'($urandom_range(1, 15));
        set_ss(1, 1'b0);
        send_word(1, 16'($urandom), n);
        set_ss(1, 1'b1);
        wcyc(2);
        check("rnd3_ferr", 32'(ecnt3 - e), 32'd1);
        check("rnd3_fvalid", 32'(vcnt3 - v), 32'd0);
        check("rnd3_fcnt", 32'(cnt3), 32'(exp_cnt));
        check("rnd3_fdata", 32'(data3), 32'(w));

        check("valid_err_overlap", 32'(both), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
